// File: rtl/simple_phase_sequencer.sv
// Multi-cycle phase sequencer for the 16-bit SIMPLE datapath: run/stop/halt control,
// memory-ready stalls and per-phase control enables decoded from the instruction.
//
// phase | meaning
// 0     | idle, waiting for an exec edge
// 1     | P1 fetch (mem read, IR load on ready)
// 2     | P2 operand register load
// 3     | P3 ALU / address compute
// 4     | P4 memory access or output port
// 5     | P5 write-back and PC update
module simple_phase_sequencer #(
    parameter int WORD_W        = 16,
    parameter bit USE_MEM_READY = 1'b1,
    parameter bit RESET_RUNNING = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exec,
    input  logic              step_mode,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] instruction,
    input  logic              S,
    input  logic              Z,
    input  logic              C,
    input  logic              V,
    output logic [2:0]        phase,
    output logic              running,
    output logic              halted,
    output logic              ir_e,
    output logic              ar_e,
    output logic              br_e,
    output logic              dr_e,
    output logic              mdr_e,
    output logic              flag_e,
    output logic              pc_e,
    output logic              out_e,
    output logic              mem_e,
    output logic              mem_w,
    output logic              genr_w,
    output logic [3:0]        alu_op,
    output logic              a_sel_pc,
    output logic              b_sel_imm,
    output logic              pc_sel_branch,
    output logic [1:0]        wb_sel,
    output logic              illegal
);

    localparam logic [2:0] PH_IDLE = 3'd0;
    localparam logic [2:0] PH_P1   = 3'd1;
    localparam logic [2:0] PH_P2   = 3'd2;
    localparam logic [2:0] PH_P3   = 3'd3;
    localparam logic [2:0] PH_P4   = 3'd4;
    localparam logic [2:0] PH_P5   = 3'd5;

    logic [2:0] phase_q, phase_d;
    logic       running_q, running_d;
    logic       halted_q, halted_d;
    logic       stop_req_q, stop_req_d;
    logic       exec_q, exec_d;

    logic [15:0] word;
    logic [1:0]  op;
    logic [2:0]  ra, rb;
    logic [3:0]  op3;
    logic        mem_rdy, exec_edge;
    logic        is_ld, is_st, is_li, is_b, is_bcc, is_alu, is_ill;
    logic        is_hlt, is_out, is_in, is_cmp, is_shift, is_mem;
    logic        cond_true;
    logic        unused_bits;

    assign word      = instruction[WORD_W-1 -: 16];
    assign op        = word[15:14];
    assign ra        = word[13:11];
    assign rb        = word[10:8];
    assign op3       = word[7:4];
    assign mem_rdy   = USE_MEM_READY ? mem_ready : 1'b1;
    assign exec_edge = exec & ~exec_q;

    assign is_ill   = (op == 2'b11 && (op3 == 4'b0111 || op3 == 4'b1110)) ||
                      (op == 2'b10 && !(ra == 3'b000 || ra == 3'b100 || ra == 3'b111)) ||
                      (op == 2'b10 && ra == 3'b111 && rb[2]);
    assign is_ld    = (op == 2'b00);
    assign is_st    = (op == 2'b01);
    assign is_li    = (op == 2'b10) && (ra == 3'b000);
    assign is_b     = (op == 2'b10) && (ra == 3'b100);
    assign is_bcc   = (op == 2'b10) && (ra == 3'b111) && !rb[2];
    assign is_alu   = (op == 2'b11) && !is_ill;
    assign is_hlt   = is_alu && (op3 == 4'b1111);
    assign is_out   = is_alu && (op3 == 4'b1101);
    assign is_in    = is_alu && (op3 == 4'b1100);
    assign is_cmp   = is_alu && (op3 == 4'b0101);
    assign is_shift = is_alu && (op3[3:2] == 2'b10);
    assign is_mem   = is_ld | is_st;

    assign unused_bits = ^{C, instruction};

    always_comb begin
        case (rb[1:0])
            2'b00:   cond_true = Z;
            2'b01:   cond_true = S ^ V;
            2'b10:   cond_true = Z | (S ^ V);
            default: cond_true = ~Z;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= PH_IDLE;
            running_q  <= RESET_RUNNING;
            halted_q   <= 1'b0;
            stop_req_q <= 1'b0;
            exec_q     <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            running_q  <= running_d;
            halted_q   <= halted_d;
            stop_req_q <= stop_req_d;
            exec_q     <= exec_d;
        end
    end

    always_comb begin
        phase_d    = phase_q;
        running_d  = running_q;
        halted_d   = halted_q;
        stop_req_d = stop_req_q;
        exec_d     = exec;
        case (phase_q)
            PH_IDLE: begin
                if (exec_edge || running_q) begin
                    phase_d    = PH_P1;
                    running_d  = 1'b1;
                    halted_d   = 1'b0;
                    stop_req_d = step_mode;
                end
            end
            PH_P1: begin
                stop_req_d = stop_req_q | exec_edge;
                if (mem_rdy) phase_d = PH_P2;
            end
            PH_P2: begin
                stop_req_d = stop_req_q | exec_edge;
                phase_d    = PH_P3;
            end
            PH_P3: begin
                stop_req_d = stop_req_q | exec_edge;
                phase_d    = PH_P4;
            end
            PH_P4: begin
                stop_req_d = stop_req_q | exec_edge;
                if (!is_mem || mem_rdy) phase_d = PH_P5;
            end
            PH_P5: begin
                // An edge landing on a stopping P5 is swallowed; only a later edge restarts.
                if (stop_req_q || is_hlt) begin
                    phase_d    = PH_IDLE;
                    running_d  = 1'b0;
                    halted_d   = is_hlt;
                    stop_req_d = 1'b0;
                end else begin
                    phase_d    = PH_P1;
                    stop_req_d = step_mode | exec_edge;
                end
            end
            default: begin
                phase_d    = PH_IDLE;
                running_d  = 1'b0;
                stop_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        ir_e = 1'b0; ar_e = 1'b0; br_e = 1'b0; dr_e = 1'b0; mdr_e = 1'b0;
        flag_e = 1'b0; pc_e = 1'b0; out_e = 1'b0; mem_e = 1'b0; mem_w = 1'b0;
        genr_w = 1'b0; alu_op = 4'b0000; a_sel_pc = 1'b0; b_sel_imm = 1'b0;
        pc_sel_branch = 1'b0; wb_sel = 2'b00; illegal = 1'b0;
        if (!rst) begin
            case (phase_q)
                PH_P1: begin
                    mem_e = 1'b1;
                    ir_e  = mem_rdy;
                end
                PH_P2: begin
                    ar_e = !is_hlt && !is_ill;
                    br_e = !is_hlt && !is_ill;
                end
                PH_P3: begin
                    dr_e      = (is_alu && !is_hlt && !is_out) || is_mem || is_b || is_bcc;
                    alu_op    = is_alu ? op3 : 4'b0000;
                    b_sel_imm = is_shift || is_mem || is_b || is_bcc;
                    a_sel_pc  = is_b || is_bcc;
                    flag_e    = is_alu && (op3 <= 4'b1011);
                end
                PH_P4: begin
                    mem_e = is_mem;
                    mem_w = is_st;
                    mdr_e = is_ld && mem_rdy;
                    out_e = is_out;
                end
                PH_P5: begin
                    pc_e          = 1'b1;
                    pc_sel_branch = is_b || (is_bcc && cond_true);
                    genr_w        = (is_alu && !is_cmp && !is_out && !is_hlt) || is_ld || is_li;
                    if (is_in)      wb_sel = 2'b10;
                    else if (is_ld) wb_sel = 2'b01;
                    else if (is_li) wb_sel = 2'b11;
                    else            wb_sel = 2'b00;
                    illegal       = is_ill;
                end
                default: ;
            endcase
        end
    end

    assign phase   = phase_q;
    assign running = running_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_simple_phase_sequencer.sv
// Bench for simple_phase_sequencer: directed scenarios plus randomized instruction
// streams, checked cycle by cycle against an instruction-level reference model.
module tb_simple_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst, exec, step_mode, mem_ready;
    logic [15:0] instruction;
    logic        S, Z, C, V;
    logic [2:0]  phase;
    logic        running, halted;
    logic        ir_e, ar_e, br_e, dr_e, mdr_e, flag_e, pc_e, out_e, mem_e, mem_w, genr_w;
    logic [3:0]  alu_op;
    logic        a_sel_pc, b_sel_imm, pc_sel_branch;
    logic [1:0]  wb_sel;
    logic        illegal;

    simple_phase_sequencer dut (
        .clk(clk), .rst(rst), .exec(exec), .step_mode(step_mode), .mem_ready(mem_ready),
        .instruction(instruction), .S(S), .Z(Z), .C(C), .V(V),
        .phase(phase), .running(running), .halted(halted),
        .ir_e(ir_e), .ar_e(ar_e), .br_e(br_e), .dr_e(dr_e), .mdr_e(mdr_e),
        .flag_e(flag_e), .pc_e(pc_e), .out_e(out_e), .mem_e(mem_e), .mem_w(mem_w),
        .genr_w(genr_w), .alu_op(alu_op), .a_sel_pc(a_sel_pc), .b_sel_imm(b_sel_imm),
        .pc_sel_branch(pc_sel_branch), .wb_sel(wb_sel), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_e, ar_e, br_e, dr_e, mdr_e, flag_e, pc_e, out_e, mem_e, mem_w, genr_w;
        logic [3:0] alu_op;
        logic       a_sel_pc, b_sel_imm, pc_sel_branch;
        logic [1:0] wb_sel;
        logic       illegal;
    } ctl_t;

    ctl_t got_ctl;
    assign got_ctl = {ir_e, ar_e, br_e, dr_e, mdr_e, flag_e, pc_e, out_e, mem_e, mem_w, genr_w,
                      alu_op, a_sel_pc, b_sel_imm, pc_sel_branch, wb_sel, illegal};

    localparam int K_ALU = 0, K_CMP = 1, K_IN = 2, K_OUT = 3, K_HLT = 4, K_LD = 5;
    localparam int K_ST = 6, K_LI = 7, K_B = 8, K_BCC = 9, K_ILL = 10;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_run, exp_halt;
    bit   stop_pending;

    logic [15:0] pool [20] = '{16'hC000, 16'hC010, 16'hC050, 16'hC0C0, 16'hC0D0, 16'hC080,
                               16'hC0B0, 16'h0905, 16'h4A01, 16'h8112, 16'hA0FF, 16'hB800,
                               16'hB9FC, 16'hBA00, 16'hBB00, 16'hBC00, 16'hC070, 16'hC0E0,
                               16'h9000, 16'hC0F0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int kind(input logic [15:0] w);
        case (w[15:14])
            2'b00: return K_LD;
            2'b01: return K_ST;
            2'b10: begin
                if (w[13:11] == 3'b000) return K_LI;
                if (w[13:11] == 3'b100) return K_B;
                if (w[13:11] == 3'b111 && !w[10]) return K_BCC;
                return K_ILL;
            end
            default: begin
                case (w[7:4])
                    4'd5:        return K_CMP;
                    4'd7, 4'd14: return K_ILL;
                    4'd12:       return K_IN;
                    4'd13:       return K_OUT;
                    4'd15:       return K_HLT;
                    default:     return K_ALU;
                endcase
            end
        endcase
    endfunction

    function automatic logic taken(input logic [1:0] cc);
        case (cc)
            2'd0:    return Z;
            2'd1:    return S != V;
            2'd2:    return Z || (S != V);
            default: return !Z;
        endcase
    endfunction

    function automatic ctl_t model(input int ph, input logic [15:0] w, input logic rdy, input logic rs);
        ctl_t c;
        int   k;
        bit   alu_class;
        c = '0;
        k = kind(w);
        alu_class = k inside {K_ALU, K_CMP, K_IN, K_OUT, K_HLT};
        if (rs) return c;
        case (ph)
            1: begin c.mem_e = 1'b1; c.ir_e = rdy; end
            2: if (k != K_HLT && k != K_ILL) begin c.ar_e = 1'b1; c.br_e = 1'b1; end
            3: begin
                c.dr_e      = k inside {K_ALU, K_CMP, K_IN, K_LD, K_ST, K_B, K_BCC};
                c.alu_op    = alu_class ? w[7:4] : 4'd0;
                c.flag_e    = alu_class && (w[7:4] <= 4'd11);
                c.b_sel_imm = (k == K_ALU && w[7:6] == 2'b10) || (k inside {K_LD, K_ST, K_B, K_BCC});
                c.a_sel_pc  = k inside {K_B, K_BCC};
            end
            4: begin
                if (k == K_LD) begin c.mem_e = 1'b1; c.mdr_e = rdy; end
                if (k == K_ST) begin c.mem_e = 1'b1; c.mem_w = 1'b1; end
                if (k == K_OUT) c.out_e = 1'b1;
            end
            5: begin
                c.pc_e          = 1'b1;
                c.pc_sel_branch = (k == K_B) || (k == K_BCC && taken(w[9:8]));
                c.genr_w        = k inside {K_ALU, K_IN, K_LD, K_LI};
                c.wb_sel        = (k == K_IN) ? 2'b10 : (k == K_LD) ? 2'b01 : (k == K_LI) ? 2'b11 : 2'b00;
                c.illegal       = (k == K_ILL);
            end
            default: ;
        endcase
        return c;
    endfunction

    task automatic cycle(input int ph, input logic [15:0] w, input logic rdy, input logic rs, input logic ex);
        ctl_t e;
        rst = rs; exec = ex; mem_ready = rdy; instruction = w;
        #1;
        e = model(ph, w, rdy, rs);
        chk($sformatf("phase_p%0d", ph), 32'(phase), 32'(ph));
        chk("running", 32'(running), 32'(exp_run));
        chk("halted", 32'(halted), 32'(exp_halt));
        chk($sformatf("ctl_p%0d_%04h", ph, w), 32'(got_ctl), 32'(e));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    task automatic start();
        cycle(0, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        exp_run  = 1'b1;
        exp_halt = 1'b0;
    endtask

    task automatic run_instr(input logic [15:0] ins, input int w1, input int w4, input int edge_ph,
                             input int rst_ph, output bit aborted);
        int   k, waits;
        bit   mem_ph;
        logic rdy, ex, rs;
        k = kind(ins);
        aborted = 1'b0;
        for (int p = 1; p <= 5; p++) begin
            mem_ph = (p == 1) || (p == 4 && (k == K_LD || k == K_ST));
            waits  = (p == 1) ? w1 : (mem_ph ? w4 : 0);
            for (int w = 0; w <= waits; w++) begin
                rdy = mem_ph ? (w == waits) : 1'($urandom_range(0, 1));
                ex  = (p == edge_ph) && (w == 0);
                rs  = (p == rst_ph) && (w == waits);
                cycle(p, (p == 1) ? 16'($urandom) : ins, rdy, rs, ex);
                if (rs) begin
                    aborted = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic exec_instr(input logic [15:0] ins, input int w1, input int w4, input int edge_ph,
                              output bit stopped);
        bit ab;
        run_instr(ins, w1, w4, edge_ph, 0, ab);
        if (edge_ph >= 1 && edge_ph <= 4) stop_pending = 1'b1;
        if (step_mode || stop_pending || kind(ins) == K_HLT) begin
            exp_run      = 1'b0;
            exp_halt     = (kind(ins) == K_HLT);
            stop_pending = 1'b0;
            stopped      = 1'b1;
        end else begin
            stopped = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          st, ab;
        logic [15:0] ins;
        int          ep;
        rst = 1'b1; exec = 1'b0; step_mode = 1'b0; mem_ready = 1'b1; instruction = 16'h0;
        S = 1'b0; Z = 1'b0; C = 1'b0; V = 1'b0;
        exp_run = 1'b0; exp_halt = 1'b0; stop_pending = 1'b0;
        @(negedge clk);
        cycle(0, 16'hC000, 1'b1, 1'b1, 1'b1);
        cycle(0, 16'h4000, 1'b1, 1'b1, 1'b0);
        idle(3);

        // Continuous run: ADD, LD with P4 stall, BLT taken / not taken, illegal with stop.
        start();
        exec_instr(16'hC000, 0, 0, 0, st);
        exec_instr(16'h0905, 0, 3, 0, st);
        S = 1'b1; V = 1'b0;
        exec_instr(16'hB9FC, 1, 0, 0, st);
        S = 1'b1; V = 1'b1;
        exec_instr(16'hB9FC, 0, 0, 0, st);
        exec_instr(16'hC070, 2, 0, 2, st);
        idle(2);

        // HLT and restart.
        start();
        exec_instr(16'hC0F0, 0, 0, 0, st);
        idle(2);
        start();
        exec_instr(16'hC000, 0, 0, 3, st);
        idle(1);

        // Single-step, including an edge on the stopping P5.
        step_mode = 1'b1;
        start();
        exec_instr(16'hC010, 0, 0, 0, st);
        idle(3);
        start();
        exec_instr(16'h0905, 1, 1, 5, st);
        idle(3);
        start();
        exec_instr(16'h8112, 0, 0, 0, st);
        idle(2);
        step_mode = 1'b0;

        // Reset in P4 of ST.
        start();
        run_instr(16'h4000, 0, 0, 0, 4, ab);
        exp_run = 1'b0; exp_halt = 1'b0; stop_pending = 1'b0;
        idle(2);

        // Randomized stream.
        start();
        for (int i = 0; i < 80; i++) begin
            {S, Z, C, V} = 4'($urandom);
            ins = ($urandom_range(0, 1) == 0) ? 16'($urandom) : pool[$urandom_range(0, 19)];
            ep  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 4)) : 0;
            exec_instr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), ep, st);
            if (st) begin
                idle(int'($urandom_range(1, 2)));
                start();
            end
        end
        exec_instr(16'hC000, 0, 0, 2, st);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
